// File: rtl/cam_capture.sv
// Camera capture front end: registers the camera bus, assembles RGB565 byte pairs into
// 12-bit pixels, classifies blue pixels and writes them into a frame buffer.
module cam_capture #(
   parameter int         H_PIX    = 320,
   parameter int         V_LINES  = 240,
   parameter logic [3:0] BLUE_MIN = 4'd10,
   parameter logic [3:0] RG_MAX   = 4'd6
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        cap_enable,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic        frame_wr_en,
   output logic [16:0] frame_wr_addr,
   output logic [15:0] frame_wr_data,
   output logic        frame_wr_blue,
   output logic        frame_done,
   output logic [16:0] blue_count,
   output logic        line_err,
   output logic        ovf_err
);

   localparam logic [16:0] FRAME_WORDS = 17'(H_PIX * V_LINES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      state, next_state;
   logic        vsync_q, href_q, vsync_prev;
   logic [7:0]  data_q;
   logic        vsync_rise, vsync_fall;
   logic        phase;
   logic [6:0]  hi_bits;
   logic        pix_vld;
   logic [11:0] pix_rgb;
   logic        pix_blue;
   logic [16:0] addr;
   logic [16:0] run_count;

   // hi carries {R[3:0], G[3:1]}, lo carries {G[0], B[3:0]}
   function automatic logic [11:0] pixel_rgb(input logic [6:0] hi, input logic [4:0] lo);
      return {hi, lo};
   endfunction

   function automatic logic is_blue(input logic [11:0] rgb);
      return (rgb[3:0] >= BLUE_MIN) && (rgb[11:8] <= RG_MAX) && (rgb[7:4] <= RG_MAX);
   endfunction

   assign vsync_rise = vsync_q & ~vsync_prev;
   assign vsync_fall = ~vsync_q & vsync_prev;

   // Input capture registers plus the delayed vsync used for edge detection
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         data_q     <= 8'h00;
         vsync_prev <= 1'b0;
      end else begin
         vsync_q    <= cam_vsync;
         href_q     <= cam_href;
         data_q     <= cam_data;
         vsync_prev <= vsync_q;
      end
   end

   // State register
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Frame sequencing
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (vsync_q && cap_enable) next_state = SYNC;   else next_state = IDLE;
         SYNC:    if (vsync_fall)            next_state = ACTIVE; else next_state = SYNC;
         ACTIVE:  if (vsync_rise)            next_state = DONE;   else next_state = ACTIVE;
         DONE:    if (cap_enable)            next_state = SYNC;   else next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Byte pairing; a half pixel left by href or vsync is dropped and flagged
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         phase    <= 1'b0;
         hi_bits  <= 7'h00;
         pix_vld  <= 1'b0;
         pix_rgb  <= 12'h000;
         pix_blue <= 1'b0;
         line_err <= 1'b0;
      end else begin
         pix_vld <= 1'b0;
         if ((state == ACTIVE) && !vsync_rise) begin
            if (href_q) begin
               if (!phase) begin
                  hi_bits <= {data_q[7:4], data_q[2:0]};
                  phase   <= 1'b1;
               end else begin
                  phase    <= 1'b0;
                  pix_vld  <= 1'b1;
                  pix_rgb  <= pixel_rgb(hi_bits, {data_q[7], data_q[4:1]});
                  pix_blue <= is_blue(pixel_rgb(hi_bits, {data_q[7], data_q[4:1]}));
               end
            end else begin
               if (phase) line_err <= 1'b1;
               phase <= 1'b0;
            end
         end else begin
            if ((state == ACTIVE) && phase) line_err <= 1'b1;
            phase <= 1'b0;
         end
      end
   end

   // Frame-buffer write port, address counter and blue statistics
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         frame_wr_en   <= 1'b0;
         frame_wr_addr <= 17'd0;
         frame_wr_data <= 16'h0000;
         frame_wr_blue <= 1'b0;
         frame_done    <= 1'b0;
         blue_count    <= 17'd0;
         ovf_err       <= 1'b0;
         addr          <= 17'd0;
         run_count     <= 17'd0;
      end else begin
         frame_wr_en <= 1'b0;
         frame_done  <= (next_state == DONE);
         if ((state == SYNC) && vsync_fall) begin
            addr <= 17'd0;
         end else if (pix_vld) begin
            if (addr == FRAME_WORDS) begin
               ovf_err <= 1'b1;
            end else begin
               frame_wr_en   <= 1'b1;
               frame_wr_addr <= addr;
               frame_wr_data <= {4'h0, pix_rgb};
               frame_wr_blue <= pix_blue;
               addr          <= addr + 17'd1;
               if (pix_blue && (run_count != FRAME_WORDS)) run_count <= run_count + 17'd1;
            end
         end
         if (state == DONE) begin
            blue_count <= run_count;
            run_count  <= 17'd0;
         end
      end
   end

endmodule
